// File: rtl/bsg_wormhole_link_arbiter.sv
// Packet-atomic round-robin arbiter sharing one ready/valid wormhole link.
// Optional stall watchdog enabled by BSG_WORMHOLE_LINK_ARB_TIMEOUT_EN.
module bsg_wormhole_link_arbiter #(
    parameter int flit_width_p     = 32,
    parameter int num_in_p         = 3,
    parameter int len_width_p      = 4,
    parameter int len_offset_p     = 8,
    parameter int timeout_cycles_p = 1024
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [num_in_p-1:0]              v_i,
    input  logic [num_in_p*flit_width_p-1:0] data_i,
    output logic [num_in_p-1:0]              ready_and_o,
    output logic                             v_o,
    output logic [flit_width_p-1:0]          data_o,
    input  logic                             ready_and_i,
    output logic [num_in_p-1:0]              grant_o,
    output logic                             busy_o,
    output logic                             timeout_o
);

    localparam int sel_w = (num_in_p > 1) ? $clog2(num_in_p) : 1;

    typedef enum logic [0:0] {IDLE, LOCKED} state_e;

    state_e                  state_r, state_n;
    logic [sel_w-1:0]        ptr_r, ptr_n;
    logic [sel_w-1:0]        lock_r, lock_n;
    logic [len_width_p-1:0]  cnt_r, cnt_n;
    logic [sel_w-1:0]        pick, sel;
    logic                    found, hs;
    logic [len_width_p-1:0]  len;
    logic [flit_width_p-1:0] flits [num_in_p];

    function automatic logic [sel_w-1:0] rr_idx(input logic [sel_w-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= num_in_p) s = s - num_in_p;
        return sel_w'(s);
    endfunction

    for (genvar i = 0; i < num_in_p; i++) begin : g_unpack
        assign flits[i] = data_i[i*flit_width_p +: flit_width_p];
    end

    // First valid input at or after the priority pointer, wrapping around.
    always_comb begin
        pick  = ptr_r;
        found = 1'b0;
        for (int k = 0; k < num_in_p; k++) begin
            if (!found && v_i[rr_idx(ptr_r, k)]) begin
                found = 1'b1;
                pick  = rr_idx(ptr_r, k);
            end
        end
    end

    assign sel    = (state_r == LOCKED) ? lock_r : pick;
    assign v_o    = (state_r == LOCKED) ? v_i[lock_r] : found;
    assign data_o = flits[sel];
    assign hs     = v_o & ready_and_i;
    assign len    = data_o[len_offset_p +: len_width_p];
    assign busy_o = (state_r == LOCKED);

    // A locked input keeps its grant even while its valid is low.
    always_comb begin
        grant_o = '0;
        if (state_r == LOCKED || found) grant_o[sel] = 1'b1;
    end

    assign ready_and_o = grant_o & {num_in_p{ready_and_i}};

    always_comb begin
        state_n = state_r;
        ptr_n   = ptr_r;
        lock_n  = lock_r;
        cnt_n   = cnt_r;
        case (state_r)
            IDLE: begin
                if (hs) begin
                    ptr_n  = (pick == sel_w'(num_in_p - 1)) ? '0 : pick + 1'b1;
                    lock_n = pick;
                    if (len != '0) begin
                        cnt_n   = len;
                        state_n = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (hs) begin
                    cnt_n = cnt_r - 1'b1;
                    if (cnt_r == len_width_p'(1)) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            ptr_r   <= '0;
            lock_r  <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            ptr_r   <= ptr_n;
            lock_r  <= lock_n;
            cnt_r   <= cnt_n;
        end
    end

`ifdef BSG_WORMHOLE_LINK_ARB_TIMEOUT_EN
    localparam int to_w = $clog2(timeout_cycles_p);

    logic [to_w-1:0] stall_r;
    logic            timeout_r;

    // The flag sets on the same edge the stall count reaches its limit.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            stall_r   <= '0;
            timeout_r <= 1'b0;
        end else if (state_r == IDLE || hs) begin
            stall_r <= '0;
        end else begin
            stall_r <= stall_r + 1'b1;
            if (stall_r == to_w'(timeout_cycles_p - 2)) timeout_r <= 1'b1;
        end
    end

    assign timeout_o = timeout_r;
`else
    assign timeout_o = 1'b0;
`endif

endmodule
